// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multi-cycle MIPS control unit.
// Holds the FSM state encoding, the instruction classes, the opcode/funct
// constants and the ALU operation codes.  The datapath ALU imports the same
// ALU op constants.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_BR     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CLS_RTYPE   = 2'd0,
        CLS_ADDI    = 2'd1,
        CLS_BEQ     = 2'd2,
        CLS_ILLEGAL = 2'd3
    } instr_cls_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd4;

    // True for classes that go through EXEC and WB.
    function automatic logic is_alu_cls(input instr_cls_e cls);
        return (cls == CLS_RTYPE) || (cls == CLS_ADDI);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction decoder.
// Maps opcode/funct to an instruction class and the ALU operation.
// Unsupported combinations come out as CLS_ILLEGAL with alu_op = ADD.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    output instr_cls_e          cls,
    output logic [ALU_OP_W-1:0] alu_op
);

    // Classify the instruction and pick its ALU operation.
    always_comb begin
        cls    = CLS_ILLEGAL;
        alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin cls = CLS_RTYPE; alu_op = ALU_ADD; end
                    FN_SUB: begin cls = CLS_RTYPE; alu_op = ALU_SUB; end
                    FN_AND: begin cls = CLS_RTYPE; alu_op = ALU_AND; end
                    FN_OR:  begin cls = CLS_RTYPE; alu_op = ALU_OR;  end
                    FN_SLT: begin cls = CLS_RTYPE; alu_op = ALU_SLT; end
                    default: begin cls = CLS_ILLEGAL; alu_op = ALU_ADD; end
                endcase
            end
            OP_ADDI: begin
                cls    = CLS_ADDI;
                alu_op = ALU_ADD;
            end
            OP_BEQ: begin
                cls    = CLS_BEQ;
                alu_op = ALU_SUB;
            end
            default: begin
                cls    = CLS_ILLEGAL;
                alu_op = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_aut.sv
// ctrl_aut: multi-cycle control unit for the MIPS datapath.
// FETCH -> DECODE -> EXEC -> WB for ALU ops, FETCH -> DECODE -> BR for BEQ,
// DECODE -> TRAP (sticky until reset) for unsupported instructions.
// Optional feature: define CTRL_RETIRE_CNT_EN to add the 32-bit `retired`
// output counting WB->FETCH and BR->FETCH transitions.
module ctrl_aut
    import ctrl_pkg::*;
#(
    parameter int AluOpWidth = 3
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    output logic                  ir_load,
    output logic                  pc_load,
    output logic                  pc_src,
    output logic                  rd_mux_s,
    output logic                  op2_mux_s,
    output logic                  write,
    output logic [AluOpWidth-1:0] alu_op,
    output logic                  illegal
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]           retired
`endif
);

    state_e              state_q, state_d;
    logic [5:0]          opcode_q, opcode_d;
    logic [5:0]          funct_q, funct_d;
    logic                illegal_q, illegal_d;

    logic [5:0]          dec_opcode_s;
    logic [5:0]          dec_funct_s;
    instr_cls_e          dec_cls_s;
    logic [ALU_OP_W-1:0] dec_alu_op_s;
    logic [ALU_OP_W-1:0] alu_op_s;

    // Decoder input: the IR only becomes valid during DECODE, so the live
    // fields are decoded there; every later state sees the latched copy.
    always_comb begin
        if (state_q == ST_DECODE) begin
            dec_opcode_s = opcode;
            dec_funct_s  = funct;
        end else begin
            dec_opcode_s = opcode_q;
            dec_funct_s  = funct_q;
        end
    end

    ctrl_decode u_decode (
        .opcode (dec_opcode_s),
        .funct  (dec_funct_s),
        .cls    (dec_cls_s),
        .alu_op (dec_alu_op_s)
    );

    // Next-state logic, opcode/funct latching and the sticky illegal flag.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opcode_d = opcode;
                funct_d  = funct;
                if (is_alu_cls(dec_cls_s)) begin
                    state_d = ST_EXEC;
                end else if (dec_cls_s == CLS_BEQ) begin
                    state_d = ST_BR;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_BR: begin
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and latched-instruction registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            opcode_q  <= 6'd0;
            funct_q   <= 6'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore output decode from state and latched class; zero is the
    // only input that reaches an output, and only in BR.
    always_comb begin
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        pc_src    = 1'b0;
        rd_mux_s  = 1'b0;
        op2_mux_s = 1'b0;
        write     = 1'b0;
        alu_op_s  = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                ir_load = 1'b1;
            end
            ST_EXEC: begin
                alu_op_s  = dec_alu_op_s;
                op2_mux_s = (dec_cls_s == CLS_ADDI);
                rd_mux_s  = (dec_cls_s == CLS_RTYPE);
            end
            ST_WB: begin
                alu_op_s  = dec_alu_op_s;
                op2_mux_s = (dec_cls_s == CLS_ADDI);
                rd_mux_s  = (dec_cls_s == CLS_RTYPE);
                write     = 1'b1;
                pc_load   = 1'b1;
                pc_src    = 1'b0;
            end
            ST_BR: begin
                alu_op_s  = ALU_SUB;
                op2_mux_s = 1'b0;
                pc_load   = 1'b1;
                pc_src    = zero;
            end
            default: begin
                ir_load = 1'b0;
            end
        endcase
    end

    assign alu_op  = AluOpWidth'(alu_op_s);
    assign illegal = illegal_q;

`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    // Count one retirement on each WB->FETCH or BR->FETCH transition.
    always_comb begin
        if ((state_q == ST_WB) || (state_q == ST_BR)) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_ctrl_aut.sv
// tb_ctrl_aut: scoreboard bench for ctrl_aut. Each cycle's stimulus and
// expected output vector are queued by an instruction model, then popped
// and compared against the DUT one cycle at a time.
module tb_ctrl_aut;
    import ctrl_pkg::*;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct  = 6'd0;
    logic       zero   = 1'b0;
    logic       ir_load, pc_load, pc_src, rd_mux_s, op2_mux_s, write, illegal;
    logic [2:0] alu_op;
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    ctrl_aut #(.AluOpWidth(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .ir_load   (ir_load),
        .pc_load   (pc_load),
        .pc_src    (pc_src),
        .rd_mux_s  (rd_mux_s),
        .op2_mux_s (op2_mux_s),
        .write     (write),
        .alu_op    (alu_op),
        .illegal   (illegal)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retired   (retired)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic [9:0] exp;
        string      name;
    } sb_item_t;

    sb_item_t sb_q[$];
    int vectors = 0;
    int fails   = 0;

    logic [9:0] obs_s;
    assign obs_s = {ir_load, pc_load, pc_src, rd_mux_s, op2_mux_s, write, alu_op, illegal};

    function automatic logic [9:0] ev(input logic ir, input logic pl, input logic ps,
                                      input logic rd, input logic o2, input logic wr,
                                      input logic [2:0] alu, input logic ill);
        return {ir, pl, ps, rd, o2, wr, alu, ill};
    endfunction

    task automatic push1(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic [9:0] exp, input string nm);
        sb_item_t it;
        it.op = op; it.fn = fn; it.z = z; it.exp = exp; it.name = nm;
        sb_q.push_back(it);
    endtask

    // Instruction model: queue one entry per cycle. Inputs outside
    // FETCH/DECODE are randomised (and zero outside BR) to show they are ignored.
    task automatic push_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int trap_n);
        int         cls;
        logic [2:0] alu;
        cls = 3;
        alu = 3'd0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin cls = 0; alu = 3'd0; end
                6'h22: begin cls = 0; alu = 3'd1; end
                6'h24: begin cls = 0; alu = 3'd2; end
                6'h25: begin cls = 0; alu = 3'd3; end
                6'h2A: begin cls = 0; alu = 3'd4; end
                default: cls = 3;
            endcase
        end else if (op == 6'h08) begin
            cls = 1;
        end else if (op == 6'h04) begin
            cls = 2;
        end
        push1(op, fn, 1'($urandom), ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), {nm, "/fetch"});
        push1(op, fn, 1'($urandom), ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), {nm, "/decode"});
        if (cls < 2) begin
            push1(6'($urandom), 6'($urandom), 1'($urandom),
                  ev(1'b0, 1'b0, 1'b0, cls == 0, cls == 1, 1'b0, alu, 1'b0), {nm, "/exec"});
            push1(6'($urandom), 6'($urandom), 1'($urandom),
                  ev(1'b0, 1'b1, 1'b0, cls == 0, cls == 1, 1'b1, alu, 1'b0), {nm, "/wb"});
        end else if (cls == 2) begin
            push1(6'($urandom), 6'($urandom), z,
                  ev(1'b0, 1'b1, z, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0), {nm, "/br"});
        end else begin
            for (int i = 0; i < trap_n; i++) begin
                push1(6'($urandom), 6'($urandom), 1'($urandom),
                      ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1), {nm, "/trap"});
            end
        end
    endtask

    task automatic drive_item(input sb_item_t it);
        opcode = it.op;
        funct  = it.fn;
        zero   = it.z;
        #1;
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        next_edge();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #2;
        vectors++;
        if (obs_s !== ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0)) begin
            fails++;
            $display("FAIL reset_outputs: got %b want %b", obs_s, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
        end
`ifdef CTRL_RETIRE_CNT_EN
        vectors++;
        if (retired !== 32'd0) begin
            fails++;
            $display("FAIL reset_retired: got %0d want 0", retired);
        end
`endif
        next_edge();
        reset = 1'b1;
    endtask

    task automatic test_rtype_add();
        sb_item_t it;
        push_instr("add", 6'h00, 6'h20, 1'b0, 0);
        while (sb_q.size() != 0) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            next_edge();
        end
    endtask

    task automatic test_addi();
        sb_item_t it;
        push_instr("addi", 6'h08, 6'h15, 1'b0, 0);
        while (sb_q.size() != 0) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            next_edge();
        end
    endtask

    task automatic test_beq();
        sb_item_t it;
        push_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0);
        push_instr("beq_z0", 6'h04, 6'h3F, 1'b0, 0);
        while (sb_q.size() != 0) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            next_edge();
        end
    endtask

    task automatic test_back_to_back();
        sb_item_t it;
        push_instr("b2b_sub", 6'h00, 6'h22, 1'b0, 0);
        push_instr("b2b_and", 6'h00, 6'h24, 1'b0, 0);
        push_instr("b2b_beq1", 6'h04, 6'h22, 1'b1, 0);
        push_instr("b2b_or", 6'h00, 6'h25, 1'b0, 0);
        push_instr("b2b_slt", 6'h00, 6'h2A, 1'b0, 0);
        push_instr("b2b_addi", 6'h08, 6'h2A, 1'b0, 0);
        push_instr("b2b_beq0", 6'h04, 6'h20, 1'b0, 0);
        push_instr("b2b_add", 6'h00, 6'h20, 1'b0, 0);
        while (sb_q.size() != 0) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            next_edge();
        end
    endtask

    task automatic test_illegal();
        sb_item_t it;
        apply_reset();
        push_instr("ill_op3f", 6'h3F, 6'h20, 1'b0, 5);
        while (sb_q.size() != 0) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            next_edge();
        end
        apply_reset();
        vectors++;
        if (illegal !== 1'b0) begin
            fails++;
            $display("FAIL illegal_after_reset: got %b want 0", illegal);
        end
        push_instr("ill_fn21", 6'h00, 6'h21, 1'b1, 4);
        while (sb_q.size() != 0) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            next_edge();
        end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        sb_item_t it;
        push_instr("mid_add", 6'h00, 6'h20, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            if (i < 3) next_edge();
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (obs_s !== ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0)) begin
            fails++;
            $display("FAIL reset_in_wb: got %b want %b", obs_s, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
        end
        sb_q.delete();
        next_edge();
        reset = 1'b1;
        push_instr("post_mid_addi", 6'h08, 6'h00, 1'b0, 0);
        while (sb_q.size() != 0) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            next_edge();
        end
    endtask

`ifdef CTRL_RETIRE_CNT_EN
    task automatic test_retire();
        sb_item_t it;
        apply_reset();
        push_instr("rt_add", 6'h00, 6'h20, 1'b0, 0);
        push_instr("rt_beq1", 6'h04, 6'h00, 1'b1, 0);
        push_instr("rt_addi", 6'h08, 6'h00, 1'b0, 0);
        push_instr("rt_beq0", 6'h04, 6'h00, 1'b0, 0);
        push_instr("rt_or", 6'h00, 6'h25, 1'b0, 0);
        while (sb_q.size() != 0) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            next_edge();
        end
        vectors++;
        if (retired !== 32'd5) begin
            fails++;
            $display("FAIL retired_count: got %0d want 5", retired);
        end
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        push_instr("rt_wrap", 6'h00, 6'h22, 1'b0, 0);
        while (sb_q.size() != 0) begin
            it = sb_q.pop_front(); drive_item(it); vectors++;
            if (obs_s !== it.exp) begin fails++; $display("FAIL %s: got %b want %b", it.name, obs_s, it.exp); end
            next_edge();
        end
        vectors++;
        if (retired !== 32'd0) begin
            fails++;
            $display("FAIL retired_wrap: got %h want 00000000", retired);
        end
    endtask
`endif

    // Watchdog bounding the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Test sequence.
    initial begin
        test_reset();
        test_rtype_add();
        test_addi();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
`ifdef CTRL_RETIRE_CNT_EN
        test_retire();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
